// File: rtl/raycast_pkg.sv
// Shared raycaster types and constants: Q2.8 fixed point, heading resolution,
// pose widths, player FSM states and the quarter-wave trig table.
package raycast_pkg;

    localparam int unsigned ONE         = 256;
    localparam int unsigned ANGLE_STEPS = 64;
    localparam int unsigned HEAD_W      = 6;
    localparam int unsigned POS_W       = 13;
    localparam int unsigned ANG_W       = 10;
    localparam int unsigned FRAC_W      = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TURN   = 3'd1,
        S_STEP   = 3'd2,
        S_QX     = 3'd3,
        S_QY     = 3'd4,
        S_COMMIT = 3'd5
    } state_t;

    // round(256 * sin(idx * 90deg / 16)) for idx = 0..16
    function automatic logic [ANG_W-1:0] quarter_sin(input logic [4:0] idx);
        logic [ANG_W-1:0] r;
        case (idx)
            5'd0:    r = ANG_W'(0);
            5'd1:    r = ANG_W'(25);
            5'd2:    r = ANG_W'(50);
            5'd3:    r = ANG_W'(74);
            5'd4:    r = ANG_W'(98);
            5'd5:    r = ANG_W'(121);
            5'd6:    r = ANG_W'(142);
            5'd7:    r = ANG_W'(162);
            5'd8:    r = ANG_W'(181);
            5'd9:    r = ANG_W'(198);
            5'd10:   r = ANG_W'(213);
            5'd11:   r = ANG_W'(226);
            5'd12:   r = ANG_W'(237);
            5'd13:   r = ANG_W'(245);
            5'd14:   r = ANG_W'(251);
            5'd15:   r = ANG_W'(255);
            default: r = ANG_W'(ONE);
        endcase
        return r;
    endfunction

    // h[5] selects the negative half-wave, h[4] mirrors within the half
    function automatic logic signed [ANG_W-1:0] sin_lut(input logic [HEAD_W-1:0] h);
        logic [4:0]       idx;
        logic [ANG_W-1:0] mag;
        idx = h[4] ? 5'(5'd16 - {1'b0, h[3:0]}) : {1'b0, h[3:0]};
        mag = quarter_sin(idx);
        return h[5] ? -$signed(mag) : $signed(mag);
    endfunction

    function automatic logic signed [ANG_W-1:0] cos_lut(input logic [HEAD_W-1:0] h);
        return sin_lut(HEAD_W'(h + HEAD_W'(ANGLE_STEPS / 4)));
    endfunction

endpackage

// File: rtl/trig_lut.sv
// Combinational heading -> Q2.8 cos/sin lookup, shared with the raycaster.
module trig_lut
    import raycast_pkg::*;
(
    input  logic        [HEAD_W-1:0] heading,
    output logic signed [ANG_W-1:0]  cos_c,
    output logic signed [ANG_W-1:0]  sin_c
);

    assign cos_c = cos_lut(heading);
    assign sin_c = sin_lut(heading);

endmodule

// File: rtl/player_controller.sv
// Per-frame player pose update: turn, move, axis-separated wall collision.
// Optional strafe movement is enabled by defining PLAYER_STRAFE_EN.
module player_controller
    import raycast_pkg::*;
#(
    parameter int SPEED         = 2,
    parameter int CELL_SHIFT    = 4,
    parameter int MAP_W         = 16,
    parameter int MAP_H         = 16,
    parameter int START_X       = 40,
    parameter int START_Y       = 40,
    parameter int START_HEADING = 0
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       frame_tick,
    input  logic                       move_fwd,
    input  logic                       move_back,
    input  logic                       turn_left,
    input  logic                       turn_right,
    input  logic                       strafe_left,
    input  logic                       strafe_right,
    output logic                       map_rd_en,
    output logic [$clog2(MAP_W)-1:0]   map_rd_x,
    output logic [$clog2(MAP_H)-1:0]   map_rd_y,
    input  logic                       map_wall,
    output logic signed [POS_W-1:0]    playerX,
    output logic signed [POS_W-1:0]    playerY,
    output logic signed [ANG_W-1:0]    angle_X,
    output logic signed [ANG_W-1:0]    angle_Y,
    output logic                       busy,
    output logic                       update_done
);

    localparam int unsigned XW = $clog2(MAP_W);
    localparam int unsigned YW = $clog2(MAP_H);
    localparam int unsigned PW = POS_W + FRAC_W;
    localparam logic signed [ANG_W-1:0] RST_COS = cos_lut(HEAD_W'(START_HEADING));
    localparam logic signed [ANG_W-1:0] RST_SIN = sin_lut(HEAD_W'(START_HEADING));

    state_t                    state, state_n;
    logic                      tick_prev;
    logic [HEAD_W-1:0]         heading, heading_n;
    logic signed [POS_W-1:0]   cand_x, cand_x_n, cand_y, cand_y_n;
    logic signed [POS_W-1:0]   pos_x_n, pos_y_n;
    logic signed [ANG_W-1:0]   ang_x_n, ang_y_n;
    logic                      q_oob, q_oob_n;
    logic                      busy_n, done_n;

    logic signed [ANG_W-1:0]   cos_c, sin_c;
    logic signed [1:0]         mv;
    logic signed [POS_W-1:0]   step_x, step_y;
    logic signed [POS_W-1:0]   qa_x, qa_y, cell_x, cell_y, new_x_c;
    logic                      oob_c, rise;

    // -1 / 0 / +1 from a key pair; both or neither pressed cancel out
    function automatic logic signed [1:0] key_dir(input logic pos, input logic neg);
        if (pos == neg) return 2'sb00;
        return pos ? 2'sb01 : 2'sb11;
    endfunction

    // (k * a * SPEED) >>> 8, arithmetic shift so negatives round toward -inf
    function automatic logic signed [POS_W-1:0] scale(input logic signed [1:0] k,
                                                      input logic signed [ANG_W-1:0] a);
        logic signed [PW-1:0] p;
        p = PW'(k) * PW'(a) * PW'(SPEED);
        return POS_W'(p >>> FRAC_W);
    endfunction

    trig_lut u_trig (
        .heading (heading),
        .cos_c   (cos_c),
        .sin_c   (sin_c)
    );

    assign rise = frame_tick & ~tick_prev;

    // Step vector for the heading committed in TURN
`ifdef PLAYER_STRAFE_EN
    logic signed [1:0] sv;
    always_comb begin
        mv     = key_dir(move_fwd, move_back);
        sv     = key_dir(strafe_right, strafe_left);
        step_x = scale(mv, cos_c) + scale(sv, ANG_W'(-sin_c));
        step_y = scale(mv, sin_c) + scale(sv, cos_c);
    end
`else
    logic unused_strafe;
    assign unused_strafe = strafe_left ^ strafe_right;
    always_comb begin
        mv     = key_dir(move_fwd, move_back);
        step_x = scale(mv, cos_c);
        step_y = scale(mv, sin_c);
    end
`endif

    // Map query address; the QY column depends on the wall answer of the QX query
    always_comb begin
        new_x_c = (q_oob | map_wall) ? playerX : cand_x;
        qa_x    = playerX;
        qa_y    = playerY;
        case (state)
            S_QX: begin
                qa_x = cand_x;
                qa_y = playerY;
            end
            S_QY: begin
                qa_x = new_x_c;
                qa_y = cand_y;
            end
            default: ;
        endcase
        cell_x    = qa_x >>> CELL_SHIFT;
        cell_y    = qa_y >>> CELL_SHIFT;
        oob_c     = qa_x[POS_W-1] | qa_y[POS_W-1]
                  | (cell_x >= POS_W'(MAP_W)) | (cell_y >= POS_W'(MAP_H));
        map_rd_en = ((state == S_QX) || (state == S_QY)) && !oob_c;
        map_rd_x  = cell_x[XW-1:0];
        map_rd_y  = cell_y[YW-1:0];
    end

    // Next-state and next-pose logic
    always_comb begin
        state_n   = state;
        heading_n = heading;
        cand_x_n  = cand_x;
        cand_y_n  = cand_y;
        q_oob_n   = q_oob;
        pos_x_n   = playerX;
        pos_y_n   = playerY;
        ang_x_n   = angle_X;
        ang_y_n   = angle_Y;
        busy_n    = busy;
        done_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_n = S_TURN;
                    busy_n  = 1'b1;
                end
            end
            S_TURN: begin
                heading_n = heading + HEAD_W'(turn_right) - HEAD_W'(turn_left);
                state_n   = S_STEP;
            end
            S_STEP: begin
                cand_x_n = playerX + step_x;
                cand_y_n = playerY + step_y;
                state_n  = S_QX;
            end
            S_QX: begin
                q_oob_n = oob_c;
                state_n = S_QY;
            end
            S_QY: begin
                cand_x_n = new_x_c;
                q_oob_n  = oob_c;
                state_n  = S_COMMIT;
            end
            S_COMMIT: begin
                pos_x_n = cand_x;
                pos_y_n = (q_oob | map_wall) ? playerY : cand_y;
                ang_x_n = cos_c;
                ang_y_n = sin_c;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= S_IDLE;
            tick_prev   <= 1'b1;
            heading     <= HEAD_W'(START_HEADING);
            cand_x      <= '0;
            cand_y      <= '0;
            q_oob       <= 1'b0;
            playerX     <= POS_W'(START_X);
            playerY     <= POS_W'(START_Y);
            angle_X     <= RST_COS;
            angle_Y     <= RST_SIN;
            busy        <= 1'b0;
            update_done <= 1'b0;
        end else begin
            state       <= state_n;
            tick_prev   <= frame_tick;
            heading     <= heading_n;
            cand_x      <= cand_x_n;
            cand_y      <= cand_y_n;
            q_oob       <= q_oob_n;
            playerX     <= pos_x_n;
            playerY     <= pos_y_n;
            angle_X     <= ang_x_n;
            angle_Y     <= ang_y_n;
            busy        <= busy_n;
            update_done <= done_n;
        end
    end

endmodule

// File: tb/tb_player_controller.sv
// Directed bench for player_controller: per-tick vector table plus hand sequences
// for out-of-bounds, heading wrap, held/dropped ticks and reset mid-update.
module tb_player_controller;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_tick = 1'b0;
    logic        move_fwd = 1'b0, move_back = 1'b0, turn_left = 1'b0, turn_right = 1'b0;
    logic        strafe_left = 1'b0, strafe_right = 1'b0;
    logic        map_rd_en;
    logic [3:0]  map_rd_x, map_rd_y;
    logic        map_wall = 1'b0;
    logic signed [12:0] playerX, playerY;
    logic signed [9:0]  angle_X, angle_Y;
    logic        busy, update_done;

    localparam logic [5:0] FWD  = 6'b100000;
    localparam logic [5:0] BACK = 6'b010000;
    localparam logic [5:0] TL   = 6'b001000;
    localparam logic [5:0] TR   = 6'b000100;
    localparam logic [5:0] SR   = 6'b000001;

    typedef struct {
        logic [5:0] keys;
        int x; int y; int ax; int ay; int q;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    logic [15:0] wall_row [16];
    int rd_count = 0;
    int passed = 0;
    int total = 0;

    player_controller dut (
        .clock        (clock),
        .resetn       (resetn),
        .frame_tick   (frame_tick),
        .move_fwd     (move_fwd),
        .move_back    (move_back),
        .turn_left    (turn_left),
        .turn_right   (turn_right),
        .strafe_left  (strafe_left),
        .strafe_right (strafe_right),
        .map_rd_en    (map_rd_en),
        .map_rd_x     (map_rd_x),
        .map_rd_y     (map_rd_y),
        .map_wall     (map_wall),
        .playerX      (playerX),
        .playerY      (playerY),
        .angle_X      (angle_X),
        .angle_Y      (angle_Y),
        .busy         (busy),
        .update_done  (update_done)
    );

    always #10 clock = ~clock;

    // Map ROM model: answer one cycle after the read strobe
    always @(posedge clock) begin
        map_wall <= map_rd_en ? wall_row[map_rd_y][map_rd_x] : 1'b0;
        if (map_rd_en) rd_count <= rd_count + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_keys(input logic [5:0] k);
        {move_fwd, move_back, turn_left, turn_right, strafe_left, strafe_right} = k;
    endtask

    // One frame tick: rise before edge 1, observe 10 cycles, then release
    task automatic run_tick(input logic [5:0] k, output int done_at, output int n_done,
                            output int queries, output logic [9:0] busy_seen);
        int q0;
        @(negedge clock);
        set_keys(k);
        frame_tick = 1'b1;
        q0 = rd_count;
        done_at = 0;
        n_done = 0;
        busy_seen = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            busy_seen[i-1] = busy;
            if (update_done) begin
                n_done++;
                if (done_at == 0) done_at = i;
            end
        end
        queries = rd_count - q0;
        frame_tick = 1'b0;
        set_keys(6'b0);
    endtask

    initial begin
        int done_at, n_done, queries, cnt, ex;
        logic [9:0] bs;

        for (int r = 0; r < 16; r++) wall_row[r] = 16'h0000;
        wall_row[2][3] = 1'b1;

        vecs[0]  = '{FWD,        42, 40, 256,   0, 2};
        vecs[1]  = '{FWD,        44, 40, 256,   0, 2};
        vecs[2]  = '{FWD,        46, 40, 256,   0, 2};
        vecs[3]  = '{FWD,        46, 40, 256,   0, 2};
        vecs[4]  = '{FWD | BACK, 46, 40, 256,   0, 2};
        vecs[5]  = '{TR,         46, 40, 255,  25, 2};
        vecs[6]  = '{TR,         46, 40, 251,  50, 2};
        vecs[7]  = '{TR,         46, 40, 245,  74, 2};
        vecs[8]  = '{TR,         46, 40, 237,  98, 2};
        vecs[9]  = '{TR,         46, 40, 226, 121, 2};
        vecs[10] = '{TR,         46, 40, 213, 142, 2};
        vecs[11] = '{TR,         46, 40, 198, 162, 2};
        vecs[12] = '{TR,         46, 40, 181, 181, 2};
        vecs[13] = '{FWD,        47, 41, 181, 181, 2};
        vecs[14] = '{FWD,        47, 42, 181, 181, 2};
        vecs[15] = '{BACK,       45, 40, 181, 181, 2};
        vecs[16] = '{TL,         45, 40, 198, 162, 2};
        vecs[17] = '{TL,         45, 40, 213, 142, 2};
        vecs[18] = '{TL,         45, 40, 226, 121, 2};
        vecs[19] = '{TL,         45, 40, 237,  98, 2};
        vecs[20] = '{TL,         45, 40, 245,  74, 2};
        vecs[21] = '{TL,         45, 40, 251,  50, 2};
        vecs[22] = '{TL,         45, 40, 255,  25, 2};
        vecs[23] = '{TL,         45, 40, 256,   0, 2};
        vecs[24] = '{BACK,       43, 40, 256,   0, 2};
        vecs[25] = '{TR | FWD,   44, 40, 255,  25, 2};
        vecs[26] = '{TL,         44, 40, 256,   0, 2};

        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (5) @(negedge clock);

        check("reset_x", playerX, 40);
        check("reset_y", playerY, 40);
        check("reset_ax", angle_X, 256);
        check("reset_ay", angle_Y, 0);
        check("reset_busy", busy, 0);
        check("reset_done", update_done, 0);
        check("reset_no_reads", rd_count, 0);

        for (int v = 0; v < NV; v++) begin
            run_tick(vecs[v].keys, done_at, n_done, queries, bs);
            check($sformatf("v%0d_x", v), playerX, vecs[v].x);
            check($sformatf("v%0d_y", v), playerY, vecs[v].y);
            check($sformatf("v%0d_ax", v), angle_X, vecs[v].ax);
            check($sformatf("v%0d_ay", v), angle_Y, vecs[v].ay);
            check($sformatf("v%0d_queries", v), queries, vecs[v].q);
            check($sformatf("v%0d_done_edge", v), done_at, 6);
            check($sformatf("v%0d_done_count", v), n_done, 1);
            if (v == 0) check("v0_busy_profile", int'(bs), 'h01F);
        end

        // Walk back into the left edge; the final candidate X<0 is a wall with no QX read
        for (int i = 0; i < 23; i++) begin
            run_tick(BACK, done_at, n_done, queries, bs);
            ex = 44 - 2 * (i + 1);
            if (ex < 0) ex = 0;
            check($sformatf("oob_walk%0d_x", i), playerX, ex);
        end
        check("oob_y", playerY, 40);
        check("oob_queries", queries, 1);

        for (int i = 0; i < 64; i++) run_tick(TR, done_at, n_done, queries, bs);
        check("wrap64_ax", angle_X, 256);
        check("wrap64_ay", angle_Y, 0);
        run_tick(TL, done_at, n_done, queries, bs);
        check("h63_ax", angle_X, 255);
        check("h63_ay", angle_Y, -25);

        // Level held high: only the first edge counts
        @(negedge clock);
        frame_tick = 1'b1;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (update_done) cnt++;
        end
        frame_tick = 1'b0;
        check("held_tick_updates", cnt, 1);

        // Second rise while busy is dropped
        @(negedge clock);
        frame_tick = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (i == 2) frame_tick = 1'b0;
            if (i == 3) frame_tick = 1'b1;
            if (update_done) cnt++;
        end
        frame_tick = 1'b0;
        check("busy_rise_dropped", cnt, 1);
        check("pose_x_after_idle_ticks", playerX, 0);

        // Reset while in QX aborts the update and swallows the held tick
        @(negedge clock);
        set_keys(FWD);
        frame_tick = 1'b1;
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        check("abort_x", playerX, 40);
        check("abort_y", playerY, 40);
        check("abort_ax", angle_X, 256);
        check("abort_ay", angle_Y, 0);
        check("abort_busy", busy, 0);
        check("abort_done", update_done, 0);
        resetn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (update_done) cnt++;
        end
        check("abort_no_update", cnt, 0);
        frame_tick = 1'b0;
        set_keys(6'b0);

        run_tick(SR, done_at, n_done, queries, bs);
        check("strafe_x", playerX, 40);
`ifdef PLAYER_STRAFE_EN
        check("strafe_y", playerY, 42);
`else
        check("strafe_y", playerY, 40);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
